fp_norm_scheduler: RTL

- Shares one instance of the existing 27-bit combinational normaliser (inputs: word, carry; output: normalised word) among NUM_REQ upstream arithmetic units, e.g. the adder and subtractor result paths.
- Arbitrates round-robin, registers the normalised result and returns it with the requester ID over a valid/ready handshake.
- Sustains one result per cycle with 1-cycle latency.

---
 rtl/fp_norm_pkg.sv | 52 +++++
 rtl/fp_norm_scheduler_rr_arbiter.sv | 32 +++
 rtl/fp_norm_scheduler.sv | 102 ++++++++++
 3 files changed

// File: rtl/fp_norm_pkg.sv
// Shared types, field layout and the 27-bit normaliser function
// used by fp_norm_scheduler.
package fp_norm_pkg;

   localparam int FP_W     = 27;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 18;
   localparam int SIGN_BIT = 26;
   localparam int EXP_MSB  = 25;
   localparam int EXP_LSB  = 18;
   localparam int FRAC_MSB = 17;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp_word_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // Carry shifts right by one; otherwise leading zeros are shifted
   // out. The exponent adder wraps silently on over/underflow.
   function automatic fp_word_t fp_normalise(
      input fp_word_t w,
      input logic     carry
   );
      fp_word_t   r;
      logic [4:0] lz;
      logic       found;
      r     = w;
      lz    = 5'd0;
      found = 1'b0;
      if (carry) begin
         r.exp  = w.exp + 8'd1;
         r.frac = {1'b1, w.frac[FRAC_MSB:1]};
      end else begin
         for (int i = FRAC_MSB; i >= 0; i--) begin
            if (!found && w.frac[i]) begin
               lz    = 5'(FRAC_MSB - i);
               found = 1'b1;
            end
         end
         r.frac = w.frac << lz;
         r.exp  = w.exp - {3'b000, lz};
      end
      return r;
   endfunction

endpackage

// File: rtl/fp_norm_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr with
// wrap-around and returns a one-hot grant plus its index.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx
);

   logic found;
   int   j;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!found && en && req[j]) begin
            gnt[j] = 1'b1;
            idx    = ID_W'(j);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_norm_scheduler.sv
// Shares one normaliser among NUM_REQ requesters, 1-cycle latency.
// Optional per-requester grant counters: FP_NORM_SCHED_STATS_EN.
module fp_norm_scheduler
   import fp_norm_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*FP_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]      req_carry,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    res_valid,
   output logic [FP_W-1:0]         res_data,
   output logic [ID_W-1:0]         res_id,
   output logic                    res_zero,
   input  logic                    res_ready
`ifdef FP_NORM_SCHED_STATS_EN
   ,
   input  logic                    stats_clr,
   output logic [NUM_REQ*16-1:0]   grant_count
`endif
);

   slot_state_t         state;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     idx;
   logic [NUM_REQ-1:0]  gnt;
   logic                load_en;
   logic                xfer;
   fp_word_t            sel;
   fp_word_t            nrm;
   logic                sel_carry;
   logic                is_zero;
   logic [FP_W-1:0]     next_data;

   assign load_en = (|req_valid) & ~rst &
                    ((state == SLOT_EMPTY) | res_ready);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .en  (load_en),
      .gnt (gnt),
      .idx (idx)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   assign sel       = req_data[int'(idx)*FP_W +: FP_W];
   assign sel_carry = req_carry[idx];
   assign nrm       = fp_normalise(sel, sel_carry);
   assign is_zero   = ~sel_carry & (sel.frac == '0);

   // Exact zero bypasses the normaliser and keeps only the sign.
   assign next_data = is_zero
      ? {sel.sign, {(EXP_W+FRAC_W){1'b0}}}
      : nrm;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SLOT_EMPTY;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         res_zero  <= 1'b0;
         ptr       <= '0;
      end else if (xfer) begin
         state     <= SLOT_FULL;
         res_valid <= 1'b1;
         res_data  <= next_data;
         res_id    <= idx;
         res_zero  <= is_zero;
         ptr       <= (int'(idx) == NUM_REQ-1)
                      ? '0 : idx + ID_W'(1);
      end else if (res_ready) begin
         state     <= SLOT_EMPTY;
         res_valid <= 1'b0;
      end
   end

`ifdef FP_NORM_SCHED_STATS_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      logic [15:0] cnt;
      always_ff @(posedge clk) begin
         if (rst || stats_clr) begin
            cnt <= '0;
         end else if (gnt[g] && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
         end
      end
      assign grant_count[g*16 +: 16] = cnt;
   end
`endif

endmodule
